// File: rtl/controlador_venda.sv
// controlador_venda: vending purchase controller covering price lookup, coin credit,
// dispense with change, and cancel/timeout refund.
module controlador_venda #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] codigo_in,
    input  logic       confirma,
    input  logic       moeda_valida,
    input  logic [3:0] moeda_valor,
    input  logic       cancela,
    output logic [3:0] codigo_produto,
    input  logic [3:0] valor_preco,
    input  logic       produto_existe,
    output logic [4:0] credito,
    output logic       libera_produto,
    output logic [4:0] troco,
    output logic       troco_valido,
    output logic       erro_produto,
    output logic       moeda_rejeitada,
    output logic [2:0] estado
);
    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        CONSULTA      = 3'd1,
        AGUARDA_MOEDA = 3'd2,
        ENTREGA       = 3'd3,
        DEVOLVE       = 3'd4
    } estado_t;

    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

    estado_t       estado_q, estado_d;
    logic [3:0]    codigo_q, codigo_d, preco_q, preco_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    credito_q, credito_d, troco_q, troco_d;
    logic          libera_q, libera_d, tv_q, tv_d, erro_q, erro_d, rej_q, rej_d;
    logic          moeda_ok, aceita;

    assign moeda_ok = moeda_valida && (moeda_valor == 4'd1 || moeda_valor == 4'd2 || moeda_valor == 4'd4);

    always_comb begin
        estado_d  = estado_q;
        codigo_d  = codigo_q;
        preco_d   = preco_q;
        cnt_d     = cnt_q;
        credito_d = credito_q;
        troco_d   = troco_q;
        libera_d  = 1'b0;
        tv_d      = 1'b0;
        erro_d    = 1'b0;
        aceita    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (confirma) begin
                    codigo_d = codigo_in;
                    estado_d = CONSULTA;
                end
            end
            CONSULTA: begin
                if (produto_existe) begin
                    preco_d  = valor_preco;
                    cnt_d    = '0;
                    estado_d = AGUARDA_MOEDA;
                end else begin
                    erro_d   = 1'b1;
                    estado_d = OCIOSO;
                end
            end
            AGUARDA_MOEDA: begin
                // Priority: cancel, paid in full, timeout, then coin acceptance
                if (cancela || (credito_q < {1'b0, preco_q} && cnt_q == CW'(TIMEOUT_CICLOS - 1))) begin
                    estado_d  = DEVOLVE;
                    troco_d   = credito_q;
                    tv_d      = 1'b1;
                    credito_d = '0;
                end else if (credito_q >= {1'b0, preco_q}) begin
                    estado_d  = ENTREGA;
                    troco_d   = credito_q - {1'b0, preco_q};
                    tv_d      = 1'b1;
                    libera_d  = 1'b1;
                    credito_d = '0;
                end else if (moeda_ok) begin
                    aceita    = 1'b1;
                    credito_d = credito_q + {1'b0, moeda_valor};
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: estado_d = OCIOSO;
        endcase
        rej_d = moeda_valida && !aceita;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            codigo_q  <= '0;
            preco_q   <= '0;
            cnt_q     <= '0;
            credito_q <= '0;
            troco_q   <= '0;
            libera_q  <= 1'b0;
            tv_q      <= 1'b0;
            erro_q    <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            codigo_q  <= codigo_d;
            preco_q   <= preco_d;
            cnt_q     <= cnt_d;
            credito_q <= credito_d;
            troco_q   <= troco_d;
            libera_q  <= libera_d;
            tv_q      <= tv_d;
            erro_q    <= erro_d;
            rej_q     <= rej_d;
        end
    end

    assign codigo_produto  = codigo_q;
    assign credito         = credito_q;
    assign libera_produto  = libera_q;
    assign troco           = troco_q;
    assign troco_valido    = tv_q;
    assign erro_produto    = erro_q;
    assign moeda_rejeitada = rej_q;
    assign estado          = estado_q;
endmodule

// File: tb/tb_controlador_venda.sv
// tb_controlador_venda: directed vector table plus a hand-written timeout sequence,
// with a small price-memory model answering codigo_produto.
module tb_controlador_venda;
    logic       clock = 1'b0;
    logic       reset, confirma, moeda_valida, cancela;
    logic [3:0] codigo_in, moeda_valor, codigo_produto, valor_preco;
    logic       produto_existe;
    logic [4:0] credito, troco;
    logic       libera_produto, troco_valido, erro_produto, moeda_rejeitada;
    logic [2:0] estado;

    int n_vec = 0;
    int n_err = 0;

    controlador_venda #(.TIMEOUT_CICLOS(16)) dut (
        .clock(clock), .reset(reset), .codigo_in(codigo_in), .confirma(confirma),
        .moeda_valida(moeda_valida), .moeda_valor(moeda_valor), .cancela(cancela),
        .codigo_produto(codigo_produto), .valor_preco(valor_preco), .produto_existe(produto_existe),
        .credito(credito), .libera_produto(libera_produto), .troco(troco), .troco_valido(troco_valido),
        .erro_produto(erro_produto), .moeda_rejeitada(moeda_rejeitada), .estado(estado)
    );

    always #5 clock = ~clock;

    // Price memory: 4->8, A->7, B->6, 3->0; everything else absent
    always_comb begin
        produto_existe = 1'b1;
        valor_preco    = 4'd0;
        case (codigo_produto)
            4'h4:    valor_preco = 4'd8;
            4'hA:    valor_preco = 4'd7;
            4'hB:    valor_preco = 4'd6;
            4'h3:    valor_preco = 4'd0;
            default: produto_existe = 1'b0;
        endcase
    end

    typedef struct packed {
        logic       rst;
        logic       conf;
        logic [3:0] cin;
        logic       mv;
        logic [3:0] mval;
        logic       canc;
        logic [2:0] est;
        logic [3:0] cod;
        logic [4:0] cred;
        logic       lib;
        logic       tv;
        logic [4:0] tro;
        logic       err;
        logic       rej;
    } vec_t;

    vec_t tab[$];

    task automatic apply(input vec_t v, input string name);
        logic [21:0] got, exp;
        @(negedge clock);
        reset        = v.rst;
        confirma     = v.conf;
        codigo_in    = v.cin;
        moeda_valida = v.mv;
        moeda_valor  = v.mval;
        cancela      = v.canc;
        @(posedge clock);
        #1;
        got = {estado, codigo_produto, credito, libera_produto, troco_valido, troco, erro_produto, moeda_rejeitada};
        exp = {v.est, v.cod, v.cred, v.lib, v.tv, v.tro, v.err, v.rej};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got est=%0d cod=%h cred=%0d lib=%b tv=%b troco=%0d err=%b rej=%b, want est=%0d cod=%h cred=%0d lib=%b tv=%b troco=%0d err=%b rej=%b",
                     name, estado, codigo_produto, credito, libera_produto, troco_valido, troco, erro_produto, moeda_rejeitada,
                     v.est, v.cod, v.cred, v.lib, v.tv, v.tro, v.err, v.rej);
        end
    endtask

    initial begin
        reset = 1'b1; confirma = 1'b0; codigo_in = '0;
        moeda_valida = 1'b0; moeda_valor = '0; cancela = 1'b0;
        //           rst conf cin  mv mval canc | est cod cred lib tv tro err rej
        tab.push_back('{1, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h0, 5'd0, 0, 0, 5'd0, 0, 0});
        // code 4, price 8, coins 4,4 -> exact payment
        tab.push_back('{0, 1, 4'h4, 0, 4'd0, 0,  3'd1, 4'h4, 5'd0, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd2, 4'h4, 5'd0, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 1, 4'd4, 0,  3'd2, 4'h4, 5'd4, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 1, 4'd4, 0,  3'd2, 4'h4, 5'd8, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd3, 4'h4, 5'd0, 1, 1, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h4, 5'd0, 0, 0, 5'd0, 0, 0});
        // code A, price 7, coins 4,4 -> change 1; confirma ignored mid-purchase
        tab.push_back('{0, 1, 4'hA, 0, 4'd0, 0,  3'd1, 4'hA, 5'd0, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd2, 4'hA, 5'd0, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 1, 4'h0, 1, 4'd4, 0,  3'd2, 4'hA, 5'd4, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 1, 4'd4, 0,  3'd2, 4'hA, 5'd8, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd3, 4'hA, 5'd0, 1, 1, 5'd1, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'hA, 5'd0, 0, 0, 5'd1, 0, 0});
        // code 1 does not exist
        tab.push_back('{0, 1, 4'h1, 0, 4'd0, 0,  3'd1, 4'h1, 5'd0, 0, 0, 5'd1, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h1, 5'd0, 0, 0, 5'd1, 1, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h1, 5'd0, 0, 0, 5'd1, 0, 0});
        // coin offered while idle
        tab.push_back('{0, 0, 4'h0, 1, 4'd2, 0,  3'd0, 4'h1, 5'd0, 0, 0, 5'd1, 0, 1});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h1, 5'd0, 0, 0, 5'd1, 0, 0});
        // code B, price 6, coin 2 then cancel with coin 4
        tab.push_back('{0, 1, 4'hB, 0, 4'd0, 0,  3'd1, 4'hB, 5'd0, 0, 0, 5'd1, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd2, 4'hB, 5'd0, 0, 0, 5'd1, 0, 0});
        tab.push_back('{0, 0, 4'h0, 1, 4'd2, 0,  3'd2, 4'hB, 5'd2, 0, 0, 5'd1, 0, 0});
        tab.push_back('{0, 0, 4'h0, 1, 4'd4, 1,  3'd4, 4'hB, 5'd0, 0, 1, 5'd2, 0, 1});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'hB, 5'd0, 0, 0, 5'd2, 0, 0});
        // code 3, price 0: dispense right away, simultaneous coin rejected
        tab.push_back('{0, 1, 4'h3, 0, 4'd0, 0,  3'd1, 4'h3, 5'd0, 0, 0, 5'd2, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd2, 4'h3, 5'd0, 0, 0, 5'd2, 0, 0});
        tab.push_back('{0, 0, 4'h0, 1, 4'd1, 0,  3'd3, 4'h3, 5'd0, 1, 1, 5'd0, 0, 1});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h3, 5'd0, 0, 0, 5'd0, 0, 0});
        // reset mid-purchase with credit 4 discards it silently
        tab.push_back('{0, 1, 4'h4, 0, 4'd0, 0,  3'd1, 4'h4, 5'd0, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd2, 4'h4, 5'd0, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 1, 4'd4, 0,  3'd2, 4'h4, 5'd4, 0, 0, 5'd0, 0, 0});
        tab.push_back('{1, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h0, 5'd0, 0, 0, 5'd0, 0, 0});
        tab.push_back('{0, 0, 4'h0, 0, 4'd0, 0,  3'd0, 4'h0, 5'd0, 0, 0, 5'd0, 0, 0});
        foreach (tab[i]) apply(tab[i], $sformatf("vec%0d", i));

        // Invalid coin 3 then coin 1, followed by the 16-cycle timeout refund
        apply('{0, 1, 4'h4, 0, 4'd0, 0, 3'd1, 4'h4, 5'd0, 0, 0, 5'd0, 0, 0}, "to_conf");
        apply('{0, 0, 4'h0, 0, 4'd0, 0, 3'd2, 4'h4, 5'd0, 0, 0, 5'd0, 0, 0}, "to_enter");
        apply('{0, 0, 4'h0, 1, 4'd3, 0, 3'd2, 4'h4, 5'd0, 0, 0, 5'd0, 0, 1}, "to_coin3");
        apply('{0, 0, 4'h0, 1, 4'd1, 0, 3'd2, 4'h4, 5'd1, 0, 0, 5'd0, 0, 0}, "to_coin1");
        for (int k = 1; k <= 15; k++)
            apply('{0, 0, 4'h0, 0, 4'd0, 0, 3'd2, 4'h4, 5'd1, 0, 0, 5'd0, 0, 0}, $sformatf("to_wait%0d", k));
        apply('{0, 0, 4'h0, 0, 4'd0, 0, 3'd4, 4'h4, 5'd0, 0, 1, 5'd1, 0, 0}, "to_refund");
        apply('{0, 0, 4'h0, 0, 4'd0, 0, 3'd0, 4'h4, 5'd0, 0, 0, 5'd1, 0, 0}, "to_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
